// File: rtl/vram_write_scheduler.sv
// Write FIFO that holds control-unit memory writes and drains them into the video memory port
// only while the renderer is not printing. Optional sticky `overflow` output with OVERFLOW_FLAG_EN.
module vram_write_scheduler #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  printtingScreen,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [DEPTH_LOG2:0]   pending,
    output logic                  busy
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                  overflow
`endif
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           pending_q, pending_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic                    push_c;
    logic                    pop_c;

    assign wr_ready    = (pending_q != CW'(DEPTH));
    assign busy        = (pending_q != '0) || mem_wr_q;
    assign push_c      = wr_req && wr_ready;
    assign mem_wr      = mem_wr_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign pending     = pending_q;

    // Next-state, pop decision and FIFO bookkeeping
    always_comb begin
        state_d       = state_q;
        pop_c         = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pending_d     = pending_q;
        mem_wr_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;

        case (state_q)
            S_IDLE: begin
                // A fresh entry is only eligible for draining on the following edge.
                if (push_c) begin
                    state_d = printtingScreen ? S_WAIT : S_DRAIN;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (printtingScreen) begin
                    state_d = S_WAIT;
                end else begin
                    pop_c = 1'b1;
                    if ((pending_q == CW'(1)) && !push_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_c) begin
            rd_ptr_d      = rd_ptr_q + DEPTH_LOG2'(1);
            mem_wr_d      = 1'b1;
            mem_address_d = addr_mem_q[rd_ptr_q];
            mem_data_d    = data_mem_q[rd_ptr_q];
        end
        if (push_c && !pop_c) begin
            pending_d = pending_q + CW'(1);
        end else if (pop_c && !push_c) begin
            pending_d = pending_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pending_q     <= '0;
            mem_wr_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            mem_wr_q      <= mem_wr_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            addr_mem_q[wr_ptr_q] <= wr_address;
            data_mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (wr_req && !wr_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: directed scenarios plus random traffic against a queue model.
module tb_vram_write_scheduler;
    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 9;
    localparam int unsigned DL    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic          printtingScreen = 1'b0;
    logic          wr_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [DL:0]   pending;
    logic          busy;
`ifdef OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    vram_write_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data),
        .wr_ready(wr_ready), .printtingScreen(printtingScreen), .mem_wr(mem_wr),
        .mem_address(mem_address), .mem_data(mem_data), .pending(pending), .busy(busy)
`ifdef OVERFLOW_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of {addr,data} and the last issued memory write.
    logic [AW+DW-1:0] q[$];
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_ovf = 1'b0;
    logic [DL:0]   e_pend = '0;
    logic          e_busy = 1'b0;
    logic          e_rdy = 1'b1;

    task automatic step(input logic rst, input logic p, input logic req,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic do_pop;
        logic do_push;
        @(negedge clk);
        reset = rst; printtingScreen = p; wr_req = req; wr_address = a; wr_data = d;
        @(posedge clk);
        if (!rst) begin
            q.delete(); m_wr = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
        end else begin
            do_pop  = (q.size() != 0) && !p;
            do_push = req && (q.size() != DEPTH);
            if (req && !do_push) m_ovf = 1'b1;
            m_wr = do_pop;
            if (do_pop) {m_addr, m_data} = q.pop_front();
            if (do_push) q.push_back({a, d});
        end
        e_pend = (DL+1)'(q.size());
        e_busy = (q.size() != 0) || m_wr;
        e_rdy  = (q.size() != DEPTH);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 14'h3FFF, 9'h1FF);
        checks++;
        if ({mem_wr, mem_address, mem_data, pending, busy, wr_ready} !== {1'b0, 14'h0, 9'h0, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset: got wr=%b a=%h d=%h pend=%0d busy=%b rdy=%b, want 0 0 0 0 0 1",
                     mem_wr, mem_address, mem_data, pending, busy, wr_ready);
        end
`ifdef OVERFLOW_FLAG_EN
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`endif
    endtask

    task automatic test_single_write();
        step(1'b1, 1'b0, 1'b1, 14'h0010, 9'h1A5);
        checks++;
        if ({mem_wr, pending} !== {1'b0, 3'd1}) begin
            failures++; $display("FAIL single_accept: got wr=%b pend=%0d want 0 1", mem_wr, pending);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, mem_address, mem_data, pending, busy} !== {1'b1, 14'h0010, 9'h1A5, 3'd0, 1'b1}) begin
            failures++; $display("FAIL single_write: got wr=%b a=%h d=%h pend=%0d busy=%b want 1 0010 1a5 0 1",
                                 mem_wr, mem_address, mem_data, pending, busy);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, mem_address, mem_data, busy} !== {1'b0, 14'h0010, 9'h1A5, 1'b0}) begin
            failures++; $display("FAIL single_after: got wr=%b a=%h d=%h busy=%b want 0 0010 1a5 0",
                                 mem_wr, mem_address, mem_data, busy);
        end
    endtask

    task automatic test_hold_print();
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b1, AW'(i), DW'(i));
        step(1'b1, 1'b1, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, pending, busy} !== {1'b0, 3'd3, 1'b1}) begin
            failures++; $display("FAIL hold_print: got wr=%b pend=%0d busy=%b want 0 3 1", mem_wr, pending, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            checks++;
            if ({mem_wr, mem_address, mem_data, pending, busy, wr_ready} !== {m_wr, m_addr, m_data, e_pend, e_busy, e_rdy}) begin
                failures++; $display("FAIL hold_release[%0d]: got wr=%b a=%h d=%h pend=%0d want wr=%b a=%h d=%h pend=%0d",
                                     i, mem_wr, mem_address, mem_data, pending, m_wr, m_addr, m_data, e_pend);
            end
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b1, AW'(16'h0100 + i), DW'(9'h040 + i));
            checks++;
            if ({wr_ready, pending} !== {(i < 4) ? 1'b1 : 1'b0, (i < 4) ? 3'(i) : 3'd4}) begin
                failures++; $display("FAIL full[%0d]: got rdy=%b pend=%0d want rdy=%b pend=%0d",
                                     i, wr_ready, pending, i < 4, (i < 4) ? i : 4);
            end
        end
`ifdef OVERFLOW_FLAG_EN
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set: got %b want 1", overflow); end
`endif
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            checks++;
            if ({mem_wr, mem_address, mem_data, pending, busy, wr_ready} !== {m_wr, m_addr, m_data, e_pend, e_busy, e_rdy}) begin
                failures++; $display("FAIL full_drain[%0d]: got wr=%b a=%h d=%h pend=%0d want wr=%b a=%h d=%h pend=%0d",
                                     i, mem_wr, mem_address, mem_data, pending, m_wr, m_addr, m_data, e_pend);
            end
        end
`ifdef OVERFLOW_FLAG_EN
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, i < 8, AW'(16'h2000 + i), DW'(9'h0F0 + i));
            checks++;
            if ({mem_wr, mem_address, mem_data, pending, busy, wr_ready} !== {m_wr, m_addr, m_data, e_pend, e_busy, e_rdy}) begin
                failures++; $display("FAIL b2b[%0d]: got wr=%b a=%h d=%h pend=%0d want wr=%b a=%h d=%h pend=%0d",
                                     i, mem_wr, mem_address, mem_data, pending, m_wr, m_addr, m_data, e_pend);
            end
            if (i >= 1 && i < 8) begin
                checks++;
                if ({pending, mem_wr, mem_address} !== {3'd1, 1'b1, AW'(16'h2000 + i - 1)}) begin
                    failures++; $display("FAIL b2b_steady[%0d]: got pend=%0d wr=%b a=%h want 1 1 %h",
                                         i, pending, mem_wr, mem_address, AW'(16'h2000 + i - 1));
                end
            end
        end
    endtask

    task automatic test_print_interrupt();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, AW'(16'h0300 + i), DW'(9'h100 + i));
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, pending, mem_address, mem_data} !== {1'b0, 3'd2, 14'h0301, 9'h101}) begin
            failures++; $display("FAIL interrupt: got wr=%b pend=%0d a=%h d=%h want 0 2 0301 101",
                                 mem_wr, pending, mem_address, mem_data);
        end
        step(1'b1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            checks++;
            if ({mem_wr, mem_address, mem_data, pending, busy} !== {m_wr, m_addr, m_data, e_pend, e_busy}) begin
                failures++; $display("FAIL interrupt_resume[%0d]: got wr=%b a=%h d=%h pend=%0d want wr=%b a=%h d=%h pend=%0d",
                                     i, mem_wr, mem_address, mem_data, pending, m_wr, m_addr, m_data, e_pend);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, AW'(16'h0500 + i), DW'(9'h0A0 + i));
        step(1'b1, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, mem_address} !== {1'b1, 14'h0500}) begin
            failures++; $display("FAIL mid_first: got wr=%b a=%h want 1 0500", mem_wr, mem_address);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({mem_wr, pending, busy, wr_ready, mem_address} !== {1'b0, 3'd0, 1'b0, 1'b1, 14'h0}) begin
            failures++; $display("FAIL mid_reset: got wr=%b pend=%0d busy=%b rdy=%b a=%h want 0 0 0 1 0",
                                 mem_wr, pending, busy, wr_ready, mem_address);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            checks++;
            if ({mem_wr, pending} !== {1'b0, 3'd0}) begin
                failures++; $display("FAIL mid_after[%0d]: got wr=%b pend=%0d want 0 0", i, mem_wr, pending);
            end
        end
    endtask

    task automatic test_random();
        logic r, p, w;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) != 0);
            p = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 3) != 0);
            step(r, p, w, AW'($urandom), DW'($urandom));
            checks++;
            if ({mem_wr, mem_address, mem_data, pending, busy, wr_ready} !== {m_wr, m_addr, m_data, e_pend, e_busy, e_rdy}) begin
                failures++; $display("FAIL random[%0d]: got wr=%b a=%h d=%h pend=%0d busy=%b rdy=%b want wr=%b a=%h d=%h pend=%0d busy=%b rdy=%b",
                                     i, mem_wr, mem_address, mem_data, pending, busy, wr_ready,
                                     m_wr, m_addr, m_data, e_pend, e_busy, e_rdy);
            end
`ifdef OVERFLOW_FLAG_EN
            checks++;
            if (overflow !== m_ovf) begin
                failures++; $display("FAIL random_overflow[%0d]: got %b want %b", i, overflow, m_ovf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_hold_print();
        test_full_overflow();
        test_reset();
        test_back_to_back();
        test_print_interrupt();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vram_write_scheduler.md
# vram_write_scheduler

Buffers memory-write requests issued by the control unit (its `memory_wr` strobe plus address/data) and drains them into the shared sprite/background memory port only while the screen renderer is not printing. It sits between the control unit and the video memory write port, so instruction writes never collide with renderer reads. It replaces the direct `memory_wr` → memory connection and gives the control unit back-pressure through `wr_ready`.

## Interface
- `ADDR_WIDTH`, 14, memory address width
- `DATA_WIDTH`, 9, memory word width
- `DEPTH_LOG2`, 2, log2 of FIFO depth; depth = 2^DEPTH_LOG2

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`
- `wr_req`  in  1  write request from control unit
- `wr_address`  in  ADDR_WIDTH  write address, valid with `wr_req`
- `wr_data`  in  DATA_WIDTH  write data, valid with `wr_req`
- `wr_ready`  out  1  FIFO not full; request accepted on an edge where `wr_req && wr_ready`
- `printtingScreen`  in  1  high = renderer owns memory port
- `mem_wr`  out  1  memory write strobe, one cycle per word
- `mem_address`  out  ADDR_WIDTH  memory address, valid while `mem_wr`
- `mem_data`  out  DATA_WIDTH  memory data, valid while `mem_wr`
- `pending`  out  DEPTH_LOG2+1  number of entries held in FIFO
- `busy`  out  1  `pending != 0` or `mem_wr` high

## Operation
- FIFO of 2^DEPTH_LOG2 entries {address, data}; binary read/write pointers of DEPTH_LOG2 bits wrapping modulo depth; `pending` counter of DEPTH_LOG2+1 bits.
- Push: `wr_req && wr_ready` → entry written at write pointer, pointer +1. `wr_req` while full is dropped; FIFO and pointers unchanged.
- `wr_ready` = `pending != 2^DEPTH_LOG2`, combinational from registered count.
- FSM states:
  - IDLE: `pending == 0`. Goes to DRAIN when an entry exists and `printtingScreen == 0`, else WAIT when an entry exists.
  - WAIT: entries present, renderer busy. Goes to DRAIN on the first edge with `printtingScreen == 0`.
  - DRAIN: each edge with `printtingScreen == 0` and `pending != 0` pops the head into the `mem_*` registers and sets `mem_wr` for the next cycle. When `pending` reaches 0 → IDLE. When `printtingScreen == 1` → WAIT.
- Simultaneous push and pop: both take effect, `pending` unchanged. A push into an empty FIFO is not drained on the same edge; it is eligible on the next edge.
- Order is strict FIFO; no reordering or merging.
- `mem_address` and `mem_data` hold their last value while `mem_wr` is low.

## Timing
- Reset (`reset == 0` at an edge): state IDLE, pointers 0, `pending` 0, `mem_wr` 0, `mem_address` 0, `mem_data` 0, `busy` 0, `wr_ready` 1. Mid-operation reset flushes all queued entries; no further writes are issued.
- Latency from accepted request to `mem_wr` high: 2 cycles minimum (edge N accept, edge N+1 pop, `mem_wr` high during cycle after N+1), with `printtingScreen` low and FIFO previously empty.
- Sustained throughput while `printtingScreen` is low: one write per cycle.
- `printtingScreen` is sampled at the edge. A write launched on an edge where it was 0 completes in the following cycle, even if `printtingScreen` rises in that cycle. The renderer raises `printtingScreen` at least one cycle before its first memory read.
- All outputs are registered except `wr_ready` and `busy`, which decode from registers only.

## Configuration
- `OVERFLOW_FLAG_EN` defined: adds output `overflow` (1 bit). It is sticky, set on any edge with `wr_req && !wr_ready`, and cleared only by reset (reset value 0).
- Not defined: no `overflow` port and no flag register. Dropped requests are silent.

## Test plan
- Reset and single write: apply `reset=0` for 2 cycles, then `reset=1`, `printtingScreen=0`. Push addr 0x0010 data 0x1A5 → `mem_wr` high for exactly 1 cycle, 2 cycles after acceptance, with 0x0010/0x1A5. `pending` returns to 0 and `busy` falls.
- Held during print: `printtingScreen=1`, push 3 words (0x0001/0x001, 0x0002/0x002, 0x0003/0x003) → no `mem_wr`, `pending`=3. Drop `printtingScreen` → 3 consecutive `mem_wr` cycles in push order.
- Full and overflow: `printtingScreen=1`, push 5 words with DEPTH_LOG2=2 → `wr_ready` low after the 4th and the 5th is dropped. With `OVERFLOW_FLAG_EN`, `overflow`=1 until reset. After release, only the first 4 words are written.
- Simultaneous push/pop: `printtingScreen=0`, push continuously for 8 cycles → `pending` holds at 1 in steady state, 8 writes appear in order, and the pointers wrap correctly.
- Print interrupt: 4 queued, `printtingScreen` rises after the 2nd pop → exactly 2 writes, `pending`=2, state WAIT. Remaining 2 are written after `printtingScreen` falls.
- Reset mid-drain: 3 queued, `reset=0` during the first `mem_wr` cycle → next cycle `mem_wr`=0, `pending`=0, and no further writes after reset is released.
